// File: rtl/act_unit.sv
// Multi-lane activation stage (bypass / ReLU / leaky ReLU / clipped ReLU) with a
// 2-stage valid/ready pipeline and a saturating count of zero-valued output lanes.
module act_unit #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [1:0]                in_mode,
    input  logic [DATA_W-1:0]         in_clip,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      stat_clr,
    output logic [CNT_W-1:0]          zero_cnt
);

    localparam int ZW = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_CLIP   = 2'd3
    } mode_t;

    mode_t                     mode;
    logic signed [DATA_W-1:0]  clip_eff;
    logic [LANES*DATA_W-1:0]   act_next;

    logic [LANES*DATA_W-1:0]   s1_data_reg;
    logic                      s1_valid_reg;
    logic [LANES*DATA_W-1:0]   out_data_reg;
    logic                      out_valid_reg;
    logic [CNT_W-1:0]          zero_cnt_reg;

    logic                      s1_load;
    logic                      s2_load;
    logic [LANES-1:0]          lane_zero;
    logic [ZW-1:0]             zero_lanes;
    logic [CNT_W:0]            cnt_sum;

    assign mode     = mode_t'(in_mode);
    // A negative clip collapses the clipped-ReLU window to zero.
    assign clip_eff = in_clip[DATA_W-1] ? '0 : $signed(in_clip);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_W-1:0] x;
            logic signed [DATA_W-1:0] y;

            assign x = $signed(in_data[gi*DATA_W +: DATA_W]);

            always_comb begin
                y = x;
                case (mode)
                    MODE_BYPASS: y = x;
                    MODE_RELU:   if (x[DATA_W-1]) y = '0;
                    MODE_LEAKY:  if (x[DATA_W-1]) y = x >>> LEAK_SHIFT;
                    MODE_CLIP: begin
                        if (x[DATA_W-1])
                            y = '0;
                        else if (x > clip_eff)
                            y = clip_eff;
                    end
                    default:     y = x;
                endcase
            end

            assign act_next[gi*DATA_W +: DATA_W] = y;
            assign lane_zero[gi] = (out_data_reg[gi*DATA_W +: DATA_W] == '0);
        end
    endgenerate

    assign s2_load  = !out_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_valid;
                if (in_valid)
                    s1_data_reg <= act_next;
            end
            if (s2_load) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg)
                    out_data_reg <= s1_data_reg;
            end
        end
    end

    always_comb begin
        zero_lanes = '0;
        for (int i = 0; i < LANES; i++)
            zero_lanes = zero_lanes + ZW'(lane_zero[i]);
    end

    // One extra bit catches the carry so the counter can stick at all-ones.
    assign cnt_sum = {1'b0, zero_cnt_reg} + (CNT_W+1)'(zero_lanes);

    always_ff @(posedge clk) begin
        if (rst || stat_clr)
            zero_cnt_reg <= '0;
        else if (out_valid_reg && out_ready)
            zero_cnt_reg <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign zero_cnt  = zero_cnt_reg;

endmodule

// File: tb/tb_act_unit.sv
// Bench for act_unit: directed vector table, backpressure/saturation/reset sequences,
// and randomized traffic checked against an arithmetic reference model and scoreboard.
`timescale 1ns/1ps
module tb_act_unit;

    localparam int DATA_W     = 16;
    localparam int LANES      = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int W          = LANES * DATA_W;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [W-1:0]      in_data   = '0;
    logic [1:0]        in_mode   = 2'd0;
    logic [DATA_W-1:0] in_clip   = '0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic              stat_clr  = 1'b0;

    logic              in_ready,   in_ready_s;
    logic              out_valid,  out_valid_s;
    logic [W-1:0]      out_data,   out_data_s;
    logic [31:0]       zero_cnt;
    logic [3:0]        zero_cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    longint       model_cnt   = 0;
    int           model_cnt_s = 0;
    logic         stall_prev  = 1'b0;
    logic [W-1:0] stall_data  = '0;
    logic [W-1:0] mon_e;
    int           mon_z;

    act_unit #(.DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_clip(in_clip),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .stat_clr(stat_clr), .zero_cnt(zero_cnt)
    );

    // Narrow-counter build, driven identically, to exercise saturation quickly.
    act_unit #(.DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_mode(in_mode), .in_clip(in_clip),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .stat_clr(stat_clr), .zero_cnt(zero_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int act_ref(input int x, input int mode, input int clip);
        int c;
        int d;
        d = 1 << LEAK_SHIFT;
        case (mode)
            1: return (x < 0) ? 0 : x;
            2: return (x < 0) ? -((-x + d - 1) / d) : x;
            3: begin
                c = (clip < 0) ? 0 : clip;
                if (x < 0) return 0;
                if (x > c) return c;
                return x;
            end
            default: return x;
        endcase
    endfunction

    function automatic logic [W-1:0] beat_ref(input logic [W-1:0] data, input logic [1:0] mode,
                                               input logic [DATA_W-1:0] clip);
        logic [W-1:0] r;
        int x;
        int y;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            x = int'($signed(data[i*DATA_W +: DATA_W]));
            y = act_ref(x, int'(mode), int'($signed(clip)));
            r[i*DATA_W +: DATA_W] = y[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic int zeros_of(input logic [W-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < LANES; i++)
            if (b[i*DATA_W +: DATA_W] == '0) n++;
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] rand_lane();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'($urandom_range(0, 40)) - 16'd20;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: samples at the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        chk("zero_cnt", 64'(zero_cnt), 64'(model_cnt));
        chk("zero_cnt_small", 64'(zero_cnt_s), 64'(model_cnt_s));
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(stall_data));
        end
        if (rst) begin
            chk("in_ready_rst", 64'(in_ready), 64'd0);
            exp_q.delete();
            model_cnt   = 0;
            model_cnt_s = 0;
            stall_prev  = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                chk("beat_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(mon_e));
                    chk("small_valid", 64'(out_valid_s), 64'd1);
                    chk("small_out_data", 64'(out_data_s), 64'(mon_e));
                    mon_z = zeros_of(mon_e);
                    model_cnt   = (model_cnt + mon_z > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : model_cnt + mon_z;
                    model_cnt_s = (model_cnt_s + mon_z > 15) ? 15 : model_cnt_s + mon_z;
                end
            end
            if (stat_clr) begin
                model_cnt   = 0;
                model_cnt_s = 0;
            end
            if (in_valid && in_ready) begin
                chk("small_in_ready", 64'(in_ready_s), 64'd1);
                exp_q.push_back(beat_ref(in_data, in_mode, in_clip));
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]             mode;
        logic [15:0]            clip;
        logic [3:0][15:0]       x;
        logic [3:0][15:0]       y;
        int                     zc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lane 0 is the rightmost element of each packed list
        vecs[0] = '{mode: 2'd1, clip: 16'd0,
                    x: {16'h8000, 16'd7, 16'd0, 16'hFFFB},
                    y: {16'd0, 16'd7, 16'd0, 16'd0}, zc: 3};
        vecs[1] = '{mode: 2'd2, clip: 16'd0,
                    x: {16'd100, 16'hFFF7, 16'hFFFF, 16'hFFF0},
                    y: {16'd100, 16'hFFFE, 16'hFFFF, 16'hFFFE}, zc: 3};
        vecs[2] = '{mode: 2'd3, clip: 16'd6,
                    x: {16'd200, 16'd6, 16'd4, 16'hFFFD},
                    y: {16'd6, 16'd6, 16'd4, 16'd0}, zc: 4};
        vecs[3] = '{mode: 2'd3, clip: 16'hFFFB,
                    x: {16'd200, 16'd6, 16'd4, 16'hFFFD},
                    y: {16'd0, 16'd0, 16'd0, 16'd0}, zc: 8};
        vecs[4] = '{mode: 2'd0, clip: 16'd0,
                    x: {16'd1234, 16'd0, 16'h7FFF, 16'hFFFF},
                    y: {16'd1234, 16'd0, 16'h7FFF, 16'hFFFF}, zc: 9};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        cyc();

        // Directed vectors: latency, in-flight isolation from mode/clip changes, counts.
        for (int k = 0; k < 5; k++) begin
            in_data  = vecs[k].x;
            in_mode  = vecs[k].mode;
            in_clip  = vecs[k].clip;
            in_valid = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            cyc();
            in_valid = 1'b0;
            in_mode  = ~vecs[k].mode;
            in_clip  = 16'($urandom);
            in_data  = 64'({$urandom, $urandom});
            @(negedge clk);
            chk("vec_latency_s1", 64'(out_valid), 64'd0);
            cyc();
            @(negedge clk);
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_data", k), 64'(out_data), 64'(vecs[k].y));
            cyc();
            @(negedge clk);
            chk($sformatf("vec%0d_zero_cnt", k), 64'(zero_cnt), 64'(vecs[k].zc));
            cyc();
        end

        // Backpressure: two beats buffered, then in_ready drops and output holds.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd2;
        in_data   = 64'({$urandom, $urandom});
        @(negedge clk);
        chk("bp_ready0", 64'(in_ready), 64'd1);
        cyc();
        in_data = 64'({$urandom, $urandom});
        @(negedge clk);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        cyc();
        in_data = 64'({$urandom, $urandom});
        @(negedge clk);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("bp_ready_hold", 64'(in_ready), 64'd0);
        end
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_comb", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();

        // Saturation of the 4-bit counter, then clear colliding with a transfer.
        in_data  = '0;
        in_mode  = 2'd0;
        in_valid = 1'b1;
        repeat (8) cyc();
        @(negedge clk);
        chk("sat_small", 64'(zero_cnt_s), 64'd15);
        cyc();
        stat_clr = 1'b1;
        @(negedge clk);
        chk("clr_with_xfer", 64'(out_valid && out_ready), 64'd1);
        cyc();
        stat_clr = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_zero_cnt", 64'(zero_cnt), 64'd0);
        chk("clr_zero_cnt_small", 64'(zero_cnt_s), 64'd0);
        repeat (4) cyc();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_data   = 64'({$urandom, $urandom});
        cyc();
        in_data = 64'({$urandom, $urandom});
        cyc();
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            chk("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        cyc();

        // Randomized traffic with toggling backpressure and occasional clears.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom);
            in_clip   = rand_lane();
            for (int l = 0; l < LANES; l++)
                in_data[l*DATA_W +: DATA_W] = rand_lane();
            out_ready = ($urandom_range(0, 2) != 0);
            stat_clr  = ($urandom_range(0, 49) == 0);
            cyc();
        end
        in_valid  = 1'b0;
        stat_clr  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            cyc();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/act_unit.md
# act_unit

Parametrised multi-lane activation stage placed between the MAC/accumulator array and the pooling/write-back path of the CNN accelerator. It applies a per-beat selectable activation to LANES signed fixed-point values at once: bypass, ReLU, leaky ReLU or clipped ReLU. It moves data through a 2-stage valid/ready pipeline with full backpressure. It also keeps a saturating count of zero-valued outputs, used for sparsity statistics.

## Interface
- DATA_W, 16: width of one signed two's-complement lane value.
- LANES, 4: number of parallel lanes per beat.
- LEAK_SHIFT, 3: arithmetic right-shift amount for the leaky-ReLU negative slope (slope = 2^-LEAK_SHIFT); legal range 0..DATA_W-1.
- CNT_W, 32: width of the zero-count statistic.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  LANES*DATA_W  input lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- in_mode  in  2  activation for this beat: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
- in_clip  in  DATA_W  signed upper clip value for mode 3.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- out_data  out  LANES*DATA_W  activated lanes, same packing as in_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- stat_clr  in  1  synchronous clear of zero_cnt.
- zero_cnt  out  CNT_W  saturating count of zero-valued lanes delivered.

## Operation
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- in_mode and in_clip are captured together with in_data in each input transfer. Mode changes between beats are therefore glitch-free, and no quiescing is required.
- Per-lane function, where x is the signed lane value:
  - Mode 0 (bypass): y = x.
  - Mode 1 (ReLU): y = 0 if x[DATA_W-1] is set, otherwise y = x.
  - Mode 2 (leaky ReLU): y = x >>> LEAK_SHIFT if x < 0, otherwise y = x.
    - The shift is arithmetic and rounds toward minus infinity, e.g. -1 gives -1 and -16 with shift 3 gives -2.
    - No saturation is needed, because the result magnitude never exceeds x.
  - Mode 3 (clipped ReLU): c = 0 if in_clip < 0, otherwise c = in_clip.
    - y = 0 if x < 0; y = c if x > c; otherwise y = x.
    - All comparisons are signed at DATA_W. No width growth occurs.
- Lanes are independent, and every lane uses the same mode and clip value within a beat.
- Pipeline structure:
  - Stage 1 (s1) registers the computed lane results plus the valid flag.
  - Stage 2 (s2) is the output register that drives out_data and out_valid.
  - s2 loads when !out_valid | out_ready.
  - s1 loads when !s1_valid | s2 loads.
  - in_ready = s1 load condition, and it is held 0 while rst is high.
- Statistics:
  - On each output transfer, zero_cnt increases by the number of lanes in out_data equal to 0, from 0 to LANES.
  - zero_cnt saturates at 2^CNT_W-1.
  - If stat_clr is high, zero_cnt becomes 0 in that cycle; clear takes priority over a simultaneous increment.

## Timing
- Reset values: out_valid 0, out_data 0, s1_valid 0, zero_cnt 0, in_ready 0 during rst. in_ready is 1 in the first cycle after rst deasserts.
- Latency: a beat accepted at edge N is presented on out_data with out_valid at edge N+2 when there is no stall.
- Throughput: 1 beat per cycle while out_ready is held high.
- Backpressure:
  - While out_valid & !out_ready, out_data is held stable.
  - s1 can absorb one more beat, after which in_ready drops.
  - Nothing is dropped or duplicated.
- in_ready depends combinationally on out_ready. No other combinational input-to-output paths exist.
- Reset mid-operation: all in-flight beats are discarded, out_valid returns to 0 on the next edge, and zero_cnt returns to 0.
- In-flight beats are unaffected by changes to in_mode or in_clip made after they are accepted.

## Test plan
- Mode 1 with lanes {-5, 0, 7, -32768}, out_ready held 1 -> {0, 0, 7, 0} two cycles later; zero_cnt becomes 3.
- Mode 2 with LEAK_SHIFT=3 and lanes {-16, -1, -9, 100} -> {-2, -1, -2, 100}.
- Mode 3 with in_clip=6 and lanes {-3, 4, 6, 200} -> {0, 4, 6, 6}. Same beat with in_clip=-5 -> {0, 0, 0, 0}.
- Stream 10 beats with alternating modes while out_ready toggles pseudo-randomly -> output order, per-beat mode and values match the model; out_data is stable during stalls; in_ready drops after 2 beats are buffered.
- Preload zero_cnt near 2^CNT_W-1 (CNT_W=4 build), then deliver zero beats -> count sticks at 15. Assert stat_clr in the same cycle as a transfer -> count is 0.
- Assert rst with 2 beats in flight -> out_valid is 0 next cycle, no stale beat appears afterwards, and in_ready is 1 after release.
